// File: rtl/fib_seq_ctrl.sv
// fib_seq_ctrl: sequencer wrapped around an external combinational ALU.
// Loads two seed terms from d on successive button presses. Each later press
// asks the ALU to add the two most recent terms and registers the sum as the
// next term. An unsigned carry out ends the sequence in a sticky overflow
// state, which only clr or rst_n can leave.
module fib_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_m,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cf,
  output logic [WIDTH-1:0] f,
  output logic [1:0]       state,
  output logic             ovf
);

  typedef enum logic [1:0] {
    LOAD0 = 2'b00,
    LOAD1 = 2'b01,
    RUN   = 2'b10,
    OVF   = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic             s0, s1;
  logic             press;
  logic [WIDTH-1:0] f1, f2;
  logic [WIDTH-1:0] f_d, f1_d, f2_d;
  logic             ovf_d;

  // Synchronise the raw button level and keep the previous sample for edge detect.
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      s0 <= en;
      s1 <= s0;
    end
  end

  // One-cycle pulse per rising edge of en, however long the button is held.
  assign press = s0 & ~s1;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LOAD0;
    else        state_q <= state_d;
  end

  // Next-state logic: clr wins over press; OVF is left only through clr.
  // NOTE: the default assignment first keeps this combinational block latch-free.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = LOAD0;
    end else if (press) begin
      case (state_q)
        LOAD0: state_d = LOAD1;
        LOAD1: state_d = RUN;
        RUN:   if (alu_cf) state_d = OVF;
        OVF:   state_d = OVF;
      endcase
    end
  end

  // Output/datapath control: the next term values each register takes at this edge.
  always_comb begin
    f_d   = f;
    f1_d  = f1;
    f2_d  = f2;
    ovf_d = ovf;
    if (clr) begin
      f_d   = '0;
      f1_d  = '0;
      f2_d  = '0;
      ovf_d = 1'b0;
    end else if (press) begin
      case (state_q)
        LOAD0: begin
          f1_d = d;
          f_d  = d;
        end
        LOAD1: begin
          f2_d = d;
          f_d  = d;
        end
        RUN: begin
          if (alu_cf) begin
            // The sum did not fit: keep the last valid term on the display.
            ovf_d = 1'b1;
          end else begin
            f1_d = f2;
            f2_d = alu_y;
            f_d  = alu_y;
          end
        end
        OVF: ;
      endcase
    end
  end

  // Term registers and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f   <= '0;
      f1  <= '0;
      f2  <= '0;
      ovf <= 1'b0;
    end else begin
      f   <= f_d;
      f1  <= f1_d;
      f2  <= f2_d;
      ovf <= ovf_d;
    end
  end

  // The ALU always sees the two latest terms and is always asked to add.
  assign alu_a = f1;
  assign alu_b = f2;
  assign alu_m = 3'b000;
  assign state = state_q;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Self-checking bench for fib_seq_ctrl at WIDTH=8 with a behavioural ALU.
module tb_fib_seq_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         clr;
  logic [W-1:0] d;
  logic [W-1:0] alu_a, alu_b, alu_y;
  logic [2:0]   alu_m;
  logic         alu_cf;
  logic [W-1:0] f;
  logic [1:0]   state;
  logic         ovf;

  int errors = 0;
  int checks = 0;

  fib_seq_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .clr    (clr),
    .d      (d),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_m  (alu_m),
    .alu_y  (alu_y),
    .alu_cf (alu_cf),
    .f      (f),
    .state  (state),
    .ovf    (ovf)
  );

  // Combinational ALU, add only, carry out of the MSB.
  assign {alu_cf, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};

  always #5 clk = ~clk;

  // Reference model: the sequence as plain integers, driven per press/clear.
  int m_f, m_old, m_new, m_st;
  bit m_ovf;

  function automatic void model_clear();
    m_f = 0; m_old = 0; m_new = 0; m_st = 0; m_ovf = 0;
  endfunction

  function automatic void model_press(input int dv);
    int sum;
    sum = m_old + m_new;
    if (m_st == 0) begin
      m_old = dv; m_f = dv; m_st = 1;
    end else if (m_st == 1) begin
      m_new = dv; m_f = dv; m_st = 2;
    end else if (m_st == 2) begin
      if (sum >= (1 << W)) begin
        m_ovf = 1; m_st = 3;
      end else begin
        m_old = m_new; m_new = sum; m_f = sum;
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_f"},     32'(f),     32'(m_f));
    check({tag, "_state"}, 32'(state), 32'(m_st));
    check({tag, "_ovf"},   32'(ovf),   32'(m_ovf));
    check({tag, "_alu_a"}, 32'(alu_a), 32'(m_old));
    check({tag, "_alu_b"}, 32'(alu_b), 32'(m_new));
  endtask

  // Full press: en rises, registers update on the second edge, en released.
  task automatic do_press(input logic [W-1:0] dv);
    d  = dv;
    en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_clear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  typedef struct {
    bit           is_clr;
    logic [W-1:0] d;
    logic [W-1:0] f;
    logic [1:0]   st;
    bit           ovf;
  } vec_t;

  vec_t vecs[21];

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{0, 8'h01, 8'h01, 2'b01, 0};
    vecs[1]  = '{0, 8'h01, 8'h01, 2'b10, 0};
    vecs[2]  = '{0, 8'h77, 8'h02, 2'b10, 0};
    vecs[3]  = '{0, 8'h00, 8'h03, 2'b10, 0};
    vecs[4]  = '{0, 8'hFF, 8'h05, 2'b10, 0};
    vecs[5]  = '{0, 8'h12, 8'h08, 2'b10, 0};
    vecs[6]  = '{1, 8'h00, 8'h00, 2'b00, 0};
    vecs[7]  = '{0, 8'h90, 8'h90, 2'b01, 0};
    vecs[8]  = '{0, 8'hE9, 8'hE9, 2'b10, 0};
    vecs[9]  = '{0, 8'h00, 8'hE9, 2'b11, 1};
    vecs[10] = '{0, 8'h55, 8'hE9, 2'b11, 1};
    vecs[11] = '{0, 8'h01, 8'hE9, 2'b11, 1};
    vecs[12] = '{1, 8'h00, 8'h00, 2'b00, 0};
    vecs[13] = '{0, 8'h00, 8'h00, 2'b01, 0};
    vecs[14] = '{0, 8'h00, 8'h00, 2'b10, 0};
    vecs[15] = '{0, 8'h44, 8'h00, 2'b10, 0};
    vecs[16] = '{0, 8'h44, 8'h00, 2'b10, 0};
    vecs[17] = '{1, 8'h00, 8'h00, 2'b00, 0};
    vecs[18] = '{0, 8'h02, 8'h02, 2'b01, 0};
    vecs[19] = '{0, 8'h03, 8'h03, 2'b10, 0};
    vecs[20] = '{0, 8'h00, 8'h05, 2'b10, 0};

    rst_n = 1'b0; en = 1'b0; clr = 1'b0; d = '0;
    model_clear();
    repeat (2) @(negedge clk);
    check("reset_f",     32'(f),     32'h0);
    check("reset_state", 32'(state), 32'h0);
    check("reset_ovf",   32'(ovf),   32'h0);
    check("reset_alu_m", 32'(alu_m), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: basic sequence, overflow at 0x90+0xE9, clear, zero seeds, reload 2,3.
    for (int i = 0; i < 21; i++) begin
      if (vecs[i].is_clr) begin
        do_clear();
        model_clear();
      end else begin
        do_press(vecs[i].d);
        model_press(int'(vecs[i].d));
      end
      check($sformatf("vec%0d_f", i),     32'(f),     32'(vecs[i].f));
      check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("vec%0d_ovf", i),   32'(ovf),   32'(vecs[i].ovf));
      check($sformatf("vec%0d_alu_m", i), 32'(alu_m), 32'h0);
    end
    check_model("after_table");

    // en held high 10 cycles in RUN with terms 3,5: exactly one advance.
    d  = 8'h00;
    en = 1'b1;
    @(negedge clk);
    check("hold_latency_f", 32'(f), 32'h05);
    @(negedge clk);
    check("hold_first_f", 32'(f), 32'h08);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("hold_cyc%0d_f", i), 32'(f), 32'h08);
    end
    en = 1'b0;
    repeat (2) @(negedge clk);
    model_press(0);
    check_model("hold_after");

    // clr and press in the same cycle in RUN: clear wins, d not loaded.
    d  = 8'hAA;
    en = 1'b1;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
    check_model("clr_press");
    repeat (2) @(negedge clk);
    check("clr_press_hold_state", 32'(state), 32'h0);
    check("clr_press_hold_f",     32'(f),     32'h0);
    en = 1'b0;
    @(negedge clk);

    // Async reset between edges during RUN.
    do_press(8'h07); model_press(7);
    do_press(8'h09); model_press(9);
    do_press(8'h00); model_press(0);
    check_model("pre_reset");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check("async_rst_f",     32'(f),     32'h0);
    check("async_rst_state", 32'(state), 32'h0);
    check("async_rst_ovf",   32'(ovf),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_press(8'h21); model_press(33);
    check_model("post_reset");

    // Randomised presses and clears against the model.
    for (int i = 0; i < 300; i++) begin
      int r;
      logic [W-1:0] dv;
      r = int'($urandom_range(0, 9));
      dv = ($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(0, 20));
      if (r == 0) begin
        do_clear();
        model_clear();
      end else begin
        do_press(dv);
        model_press(int'(dv));
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      check_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
